slc3_sram_bridge: RTL and testbench
===================================

# slc3_sram_bridge

On-chip memory stage directly downstream of the SLC-3 top level. It consumes the CPU memory port (ADDR, active-low OE/WE, Data_to_SRAM) and returns Data_from_SRAM from a synchronous block RAM. After reset it first runs a program-load phase: an external loader streams words in over a valid/ready handshake. Only then does it open the memory to the CPU and raise Ready, which board logic uses to gate Run.

## Interface
- ADDR_W, default 10: RAM address width; depth = 2**ADDR_W words of 16 bits.
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- ADDR  in  16  CPU word address (the MAR value).
- OE  in  1  CPU read enable, active-low.
- WE  in  1  CPU write enable, active-low.
- Data_to_SRAM  in  16  CPU write data.
- Data_from_SRAM  out  16  registered read data to the CPU.
- Ld_Valid  in  1  loader word valid.
- Ld_Data  in  16  loader word.
- Ld_Last  in  1  final loader word; qualified by Ld_Valid.
- Ld_Ready  out  1  bridge accepts a loader word this cycle.
- Ready  out  1  load phase finished; CPU port live.
- Load_Count  out  ADDR_W+1  number of words accepted in the current load.
- Oob  out  1  sticky flag: the CPU accessed an address ≥ depth.

## Operation
- The FSM has two states, LOAD and RUN. Reset forces LOAD.
- **LOAD**
  - Ld_Ready = 1 and Ready = 0.
  - A word is accepted when Ld_Valid & Ld_Ready at a clock edge. It is written to RAM[Load_Count[ADDR_W-1:0]], and Load_Count increments by 1.
  - LOAD → RUN on acceptance of a word with Ld_Last = 1.
  - LOAD → RUN also on acceptance of word number 2**ADDR_W (Load_Count reaches depth), whether or not Ld_Last is set. Load_Count saturates at depth and never wraps.
  - CPU OE/WE are ignored. Data_from_SRAM is held at 0.
- **RUN**
  - Ld_Ready = 0, Ready = 1. Loader inputs are ignored.
  - Only a reset leaves RUN.
- **CPU access in RUN**, sampled at each clock edge:
  - Write: WE = 0 and ADDR in range → RAM[ADDR[ADDR_W-1:0]] ← Data_to_SRAM. If WE stays low for several cycles, each cycle rewrites the word.
  - Read: OE = 0 and WE = 1 and ADDR in range → Data_from_SRAM ← RAM[ADDR] on that edge.
  - OE = 0 and WE = 0 together: the write happens and Data_from_SRAM holds its previous value.
  - OE = 1 and WE = 1: Data_from_SRAM holds its value.
- **Out of range**: ADDR[15:ADDR_W] ≠ 0.
  - An out-of-range write is dropped.
  - An out-of-range read loads Data_from_SRAM with 0.
  - Either access sets Oob, which stays set until reset.
- **Reset**: RAM contents have no reset and survive it. Reset mid-load restarts the load at address 0 with Load_Count = 0; words already written stay in RAM until overwritten.

## Timing
- Reset values: Data_from_SRAM = 0, Ld_Ready = 1, Ready = 0, Load_Count = 0, Oob = 0, state = LOAD.
- Read latency is one clock. OE low sampled at edge N → data valid after edge N and stable until the next qualifying read. This fits the SLC-3 wait state between MAR load and MDR load.
- Read-after-write to the same address on consecutive edges returns the newly written data. A write at edge N followed by a read at edge N+1 gives the new word after N+1.
- Loader throughput is one word per clock. Ld_Ready is a pure function of state (no combinational path from Ld_Valid).
- Ready rises one clock after the edge that accepts the final word. A CPU access on that same edge is ignored.
- Oob rises on the edge that samples the offending access.
- Reset assertion clears all registers immediately, without waiting for a clock edge. Deassertion takes effect at the next Clk edge.

## Test plan
- **Basic load**: stream 0x1111, 0x2222, 0x3333 with Ld_Last on the third, ADDR_W = 10 → Load_Count = 3, Ready = 1 the cycle after the third accept, Ld_Ready = 0.
- **CPU read**: in RUN, ADDR = 0x0001, OE = 0 for one edge → Data_from_SRAM = 0x2222 one clock later, held after OE returns high.
- **Write then read**:
  - ADDR = 0x0005, WE = 0, Data_to_SRAM = 0xBEEF; next edge OE = 0 → Data_from_SRAM = 0xBEEF.
  - Next, OE = 0 and WE = 0 together → the write happens, Data_from_SRAM unchanged.
- **Out of range**: ADDR = 0x0400, WE = 0, Data_to_SRAM = 0x1234 → Oob = 1. Then a read of 0x0400 returns 0. A read of 0x0000 returns 0x1111, showing no aliasing.
- **Saturating load**: ADDR_W = 4, stream 20 words with Ld_Last = 0 and Ld_Valid held high → exactly 16 words accepted, Load_Count = 16, Ready = 1. Words 17–20 are ignored and RAM[0] holds the first word.
- **Reset mid-load**:
  - Accept 2 words, then pulse Reset low between clock edges → Load_Count = 0, Ready = 0, Ld_Ready = 1 without any clock edge.
  - Reload 1 word 0xAAAA with Ld_Last → RAM[0] = 0xAAAA and RAM[1] keeps the old value.

Source files
------------

// File: rtl/slc3_sram_bridge.sv
// slc3_sram_bridge
//
// On-chip memory stage that sits directly below the SLC-3 top level. After
// reset it runs a program-load phase in which an external loader streams
// 16-bit words over a valid/ready handshake into consecutive RAM addresses
// starting at 0. Once the last word arrives (or the RAM is full) the bridge
// raises Ready and serves the CPU memory port from the same block RAM.
//
// Ports:
//   Clk            system clock, rising-edge active
//   Reset          asynchronous, active-low reset
//   ADDR           CPU word address (MAR)
//   OE, WE         CPU read / write enables, active-low
//   Data_to_SRAM   CPU write data
//   Data_from_SRAM registered read data back to the CPU (1-clock latency)
//   Ld_Valid       loader word valid
//   Ld_Data        loader word
//   Ld_Last        marks the final loader word (qualified by Ld_Valid)
//   Ld_Ready       bridge accepts a loader word this cycle
//   Ready          load phase finished, CPU port live
//   Load_Count     words accepted in the current load (saturates at depth)
//   Oob            sticky: CPU touched an address beyond the RAM depth

module slc3_sram_bridge #(
    parameter int ADDR_W = 10
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [15:0]       ADDR,
    input  logic              OE,
    input  logic              WE,
    input  logic [15:0]       Data_to_SRAM,
    output logic [15:0]       Data_from_SRAM,
    input  logic              Ld_Valid,
    input  logic [15:0]       Ld_Data,
    input  logic              Ld_Last,
    output logic              Ld_Ready,
    output logic              Ready,
    output logic [ADDR_W:0]   Load_Count,
    output logic              Oob
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t state, next_state;

    logic [15:0]       mem [DEPTH];

    logic              accept;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [15:0]       mem_wdata;
    logic              cpu_read;
    logic              oob_hit;
    logic              addr_oob;

    // Any set bit above the RAM index field means the access misses the RAM.
    assign addr_oob = |(ADDR >> ADDR_W);

    // Next-state and datapath steering. The loader and the CPU never share a
    // cycle, so the single RAM write port is simply muxed by state.
    // Ld_Ready depends on state only, so no combinational path from Ld_Valid.
    always_comb begin
        next_state = state;
        Ld_Ready   = 1'b0;
        Ready      = 1'b0;
        accept     = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = ADDR[ADDR_W-1:0];
        mem_wdata  = Data_to_SRAM;
        cpu_read   = 1'b0;
        oob_hit    = 1'b0;

        case (state)
            ST_LOAD: begin
                Ld_Ready = 1'b1;
                accept   = Ld_Valid;
                if (accept) begin
                    mem_we    = 1'b1;
                    mem_waddr = Load_Count[ADDR_W-1:0];
                    mem_wdata = Ld_Data;
                    // Count at depth-1 means this word fills the RAM.
                    if (Ld_Last || (&Load_Count[ADDR_W-1:0]))
                        next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                Ready    = 1'b1;
                mem_we   = !WE && !addr_oob;
                cpu_read = !OE && WE;
                oob_hit  = (!OE || !WE) && addr_oob;
            end
            default: next_state = ST_LOAD;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            state <= ST_LOAD;
        else
            state <= next_state;
    end

    // The count never passes depth because the FSM leaves LOAD on the
    // accept that brings it there.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            Load_Count <= '0;
        else if (accept)
            Load_Count <= Load_Count + 1'b1;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            Oob <= 1'b0;
        else if (oob_hit)
            Oob <= 1'b1;
    end

    // Read data holds between qualifying reads; out-of-range reads return 0
    // instead of aliasing onto a low address.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            Data_from_SRAM <= '0;
        else if (state == ST_LOAD)
            Data_from_SRAM <= '0;
        else if (cpu_read)
            Data_from_SRAM <= addr_oob ? 16'h0000 : mem[ADDR[ADDR_W-1:0]];
    end

    // RAM array has no reset so that its contents survive a reset.
    always_ff @(posedge Clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

endmodule

// File: tb/tb_slc3_sram_bridge.sv
// tb_slc3_sram_bridge
//
// Bench for slc3_sram_bridge. A full-size instance (ADDR_W = 10) is driven by
// hand sequences, a table of CPU vectors, and randomized traffic checked
// against a word-level memory model. A small instance (ADDR_W = 4) covers the
// saturating load.

module tb_slc3_sram_bridge;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic        Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Full-size instance signals
    logic        Reset;
    logic [15:0] ADDR;
    logic        OE, WE;
    logic [15:0] Data_to_SRAM;
    logic [15:0] Data_from_SRAM;
    logic        Ld_Valid;
    logic [15:0] Ld_Data;
    logic        Ld_Last;
    logic        Ld_Ready;
    logic        Ready;
    logic [AW:0] Load_Count;
    logic        Oob;

    // Small instance signals
    logic        Reset_s;
    logic [15:0] ADDR_s;
    logic        OE_s, WE_s;
    logic [15:0] Data_to_SRAM_s;
    logic [15:0] Data_from_SRAM_s;
    logic        Ld_Valid_s;
    logic [15:0] Ld_Data_s;
    logic        Ld_Last_s;
    logic        Ld_Ready_s;
    logic        Ready_s;
    logic [4:0]  Load_Count_s;
    logic        Oob_s;

    slc3_sram_bridge #(.ADDR_W(AW)) dut (
        .Clk(Clk), .Reset(Reset), .ADDR(ADDR), .OE(OE), .WE(WE),
        .Data_to_SRAM(Data_to_SRAM), .Data_from_SRAM(Data_from_SRAM),
        .Ld_Valid(Ld_Valid), .Ld_Data(Ld_Data), .Ld_Last(Ld_Last),
        .Ld_Ready(Ld_Ready), .Ready(Ready), .Load_Count(Load_Count), .Oob(Oob)
    );

    slc3_sram_bridge #(.ADDR_W(4)) dut_small (
        .Clk(Clk), .Reset(Reset_s), .ADDR(ADDR_s), .OE(OE_s), .WE(WE_s),
        .Data_to_SRAM(Data_to_SRAM_s), .Data_from_SRAM(Data_from_SRAM_s),
        .Ld_Valid(Ld_Valid_s), .Ld_Data(Ld_Data_s), .Ld_Last(Ld_Last_s),
        .Ld_Ready(Ld_Ready_s), .Ready(Ready_s), .Load_Count(Load_Count_s), .Oob(Oob_s)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Word-level reference model of the full-size instance
    logic [15:0] m_mem   [DEPTH];
    bit          m_known [DEPTH];
    bit          m_run;
    int          m_cnt;
    bit          m_oob;
    logic [15:0] m_dout;
    bit          m_dout_known;

    typedef struct {
        string       name;
        bit          oe;
        bit          we;
        logic [15:0] addr;
        logic [15:0] din;
        logic [15:0] exp_dout;
        bit          exp_oob;
    } cpu_vec_t;

    cpu_vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_run        = 1'b0;
        m_cnt        = 0;
        m_oob        = 1'b0;
        m_dout       = 16'h0000;
        m_dout_known = 1'b1;
    endtask

    // One clock edge of behaviour, computed from the inputs present at it.
    task automatic model_edge();
        bit oob;
        if (!m_run) begin
            if (Ld_Valid) begin
                m_mem[m_cnt]   = Ld_Data;
                m_known[m_cnt] = 1'b1;
                m_cnt++;
                if (Ld_Last || m_cnt == DEPTH) m_run = 1'b1;
            end
        end else begin
            oob = (int'(ADDR) >= DEPTH);
            if ((!OE || !WE) && oob) m_oob = 1'b1;
            if (!WE && !oob) begin
                m_mem[ADDR]   = Data_to_SRAM;
                m_known[ADDR] = 1'b1;
            end
            if (!OE && WE) begin
                if (oob) begin
                    m_dout       = 16'h0000;
                    m_dout_known = 1'b1;
                end else begin
                    m_dout       = m_mem[ADDR];
                    m_dout_known = m_known[ADDR];
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".Ready"},      32'(Ready),      32'(m_run));
        check({tag, ".Ld_Ready"},   32'(Ld_Ready),   32'(!m_run));
        check({tag, ".Load_Count"}, 32'(Load_Count), 32'(m_cnt));
        check({tag, ".Oob"},        32'(Oob),        32'(m_oob));
        if (m_dout_known)
            check({tag, ".Data"},   32'(Data_from_SRAM), 32'(m_dout));
    endtask

    task automatic applyStimulus(input bit oe, input bit we, input logic [15:0] addr,
                                 input logic [15:0] din, input bit ldv,
                                 input logic [15:0] ldd, input bit ldl, input string tag);
        OE           = oe;
        WE           = we;
        ADDR         = addr;
        Data_to_SRAM = din;
        Ld_Valid     = ldv;
        Ld_Data      = ldd;
        Ld_Last      = ldl;
        @(posedge Clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        OE = 1'b1; WE = 1'b1; ADDR = 16'h0; Data_to_SRAM = 16'h0;
        Ld_Valid = 1'b0; Ld_Data = 16'h0; Ld_Last = 1'b0;
    endtask

    // Reset pulse placed between clock edges; outputs must clear with no edge.
    task automatic reset_pulse(input string tag);
        idle_inputs();
        #2;
        Reset = 1'b0;
        model_reset();
        #1;
        check({tag, ".rst.Load_Count"}, 32'(Load_Count), 32'd0);
        check({tag, ".rst.Ready"},      32'(Ready), 32'd0);
        check({tag, ".rst.Ld_Ready"},   32'(Ld_Ready), 32'd1);
        check({tag, ".rst.Oob"},        32'(Oob), 32'd0);
        check({tag, ".rst.Data"},       32'(Data_from_SRAM), 32'd0);
        #2;
        Reset = 1'b1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] exp_dout, input bit exp_oob);
        check({name, ".dout"}, 32'(Data_from_SRAM), 32'(exp_dout));
        check({name, ".oob"},  32'(Oob), 32'(exp_oob));
    endtask

    task automatic random_round(input int round);
        int len;
        int guard;
        bit ldv;
        logic [15:0] a;
        len   = int'($urandom_range(1, 12));
        guard = 0;
        while (!m_run && guard < 100) begin
            ldv = ($urandom_range(0, 9) < 7);
            applyStimulus(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                          ldv, 16'($urandom),
                          ldv ? (m_cnt == len - 1) : 1'($urandom),
                          $sformatf("rnd%0d.load", round));
            guard++;
        end
        check($sformatf("rnd%0d.load_done", round), 32'(m_run), 32'd1);
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 7) == 0)
                a = 16'($urandom_range(DEPTH, 16'hFFFF));
            else if ($urandom_range(0, 7) == 0)
                a = 16'(DEPTH - 1);
            else
                a = 16'($urandom_range(0, 31));
            applyStimulus(1'($urandom), 1'($urandom), a, 16'($urandom),
                          1'($urandom), 16'($urandom), 1'($urandom),
                          $sformatf("rnd%0d.cpu%0d", round, i));
        end
    endtask

    task automatic small_step(input bit oe, input logic [15:0] addr, input bit ldv,
                              input logic [15:0] ldd);
        OE_s = oe; WE_s = 1'b1; ADDR_s = addr; Data_to_SRAM_s = 16'h0;
        Ld_Valid_s = ldv; Ld_Data_s = ldd; Ld_Last_s = 1'b0;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b0;
        Reset_s = 1'b0;
        idle_inputs();
        OE_s = 1'b1; WE_s = 1'b1; ADDR_s = 16'h0; Data_to_SRAM_s = 16'h0;
        Ld_Valid_s = 1'b0; Ld_Data_s = 16'h0; Ld_Last_s = 1'b0;
        model_reset();

        #3;
        check("reset.Data",       32'(Data_from_SRAM), 32'd0);
        check("reset.Ld_Ready",   32'(Ld_Ready), 32'd1);
        check("reset.Ready",      32'(Ready), 32'd0);
        check("reset.Load_Count", 32'(Load_Count), 32'd0);
        check("reset.Oob",        32'(Oob), 32'd0);
        #5;
        Reset = 1'b1;

        // Reset in the middle of a load restarts it at address 0.
        applyStimulus(1, 1, 16'h0, 16'h0, 1, 16'h5555, 0, "midload.w0");
        applyStimulus(1, 1, 16'h0, 16'h0, 1, 16'h6666, 0, "midload.w1");
        check("midload.count2", 32'(Load_Count), 32'd2);
        reset_pulse("midload");
        applyStimulus(1, 1, 16'h0, 16'h0, 1, 16'hAAAA, 1, "reload.w0");
        check("reload.Ready", 32'(Ready), 32'd1);
        applyStimulus(0, 1, 16'h0000, 16'h0, 0, 16'h0, 0, "reload.rd0");
        check("reload.ram0", 32'(Data_from_SRAM), 32'hAAAA);
        applyStimulus(0, 1, 16'h0001, 16'h0, 0, 16'h0, 0, "reload.rd1");
        check("reload.ram1_kept", 32'(Data_from_SRAM), 32'h6666);

        // Basic load; CPU writes during load, including on the final edge, are ignored.
        reset_pulse("basic");
        applyStimulus(1, 0, 16'h0400, 16'h1234, 1, 16'h1111, 0, "basic.w0");
        applyStimulus(1, 1, 16'h0000, 16'h0000, 1, 16'h2222, 0, "basic.w1");
        check("basic.not_ready_yet", 32'(Ready), 32'd0);
        applyStimulus(1, 0, 16'h0002, 16'hDEAD, 1, 16'h3333, 1, "basic.w2");
        check("basic.Load_Count", 32'(Load_Count), 32'd3);
        check("basic.Ready",      32'(Ready), 32'd1);
        check("basic.Ld_Ready",   32'(Ld_Ready), 32'd0);
        check("basic.Oob",        32'(Oob), 32'd0);

        // CPU vector table
        vecs.push_back('{"rd1",        0, 1, 16'h0001, 16'h0000, 16'h2222, 0});
        vecs.push_back('{"hold",       1, 1, 16'h0001, 16'h0000, 16'h2222, 0});
        vecs.push_back('{"rd2",        0, 1, 16'h0002, 16'h0000, 16'h3333, 0});
        vecs.push_back('{"wr5",        1, 0, 16'h0005, 16'hBEEF, 16'h3333, 0});
        vecs.push_back('{"rd5",        0, 1, 16'h0005, 16'h0000, 16'hBEEF, 0});
        vecs.push_back('{"rdwr5",      0, 0, 16'h0005, 16'hCAFE, 16'hBEEF, 0});
        vecs.push_back('{"rd5b",       0, 1, 16'h0005, 16'h0000, 16'hCAFE, 0});
        vecs.push_back('{"wrtop",      1, 0, 16'h03FF, 16'h7777, 16'hCAFE, 0});
        vecs.push_back('{"rdtop",      0, 1, 16'h03FF, 16'h0000, 16'h7777, 0});
        vecs.push_back('{"oobwr",      1, 0, 16'h0400, 16'h1234, 16'h7777, 1});
        vecs.push_back('{"oobrd",      0, 1, 16'h0400, 16'h0000, 16'h0000, 1});
        vecs.push_back('{"rd0",        0, 1, 16'h0000, 16'h0000, 16'h1111, 1});
        vecs.push_back('{"oobrdFFFF",  0, 1, 16'hFFFF, 16'h0000, 16'h0000, 1});
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].oe, vecs[i].we, vecs[i].addr, vecs[i].din,
                          0, 16'h0, 0, {"vec.", vecs[i].name});
            checkOutput({"vec.", vecs[i].name}, vecs[i].exp_dout, vecs[i].exp_oob);
        end

        // RAM survives reset; Oob is cleared by it.
        reset_pulse("survive");
        applyStimulus(1, 1, 16'h0, 16'h0, 1, 16'h9999, 1, "survive.w0");
        applyStimulus(0, 1, 16'h0005, 16'h0, 0, 16'h0, 0, "survive.rd5");
        checkOutput("survive.rd5", 16'hCAFE, 0);

        // Randomized traffic against the model
        for (int r = 0; r < 4; r++) begin
            reset_pulse($sformatf("rnd%0d", r));
            random_round(r);
        end

        // Saturating load on the 16-word instance
        #2;
        Reset_s = 1'b1;
        for (int i = 0; i < 20; i++) begin
            small_step(1, 16'h0, 1, 16'(16'h0100 + i));
            check($sformatf("sat.count%0d", i), 32'(Load_Count_s), 32'((i + 1 < 16) ? i + 1 : 16));
            check($sformatf("sat.ready%0d", i), 32'(Ready_s), 32'((i + 1 >= 16) ? 1 : 0));
        end
        check("sat.Ld_Ready", 32'(Ld_Ready_s), 32'd0);
        small_step(0, 16'h0000, 1, 16'hFFFF);
        check("sat.ram0", 32'(Data_from_SRAM_s), 32'h0100);
        small_step(0, 16'h000F, 0, 16'h0);
        check("sat.ram15", 32'(Data_from_SRAM_s), 32'h010F);
        small_step(0, 16'h0010, 0, 16'h0);
        check("sat.oobrd", 32'(Data_from_SRAM_s), 32'h0000);
        check("sat.oob",   32'(Oob_s), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
